// File: rtl/lcd_seq_pkg.sv
// Shared command codes, FSM encoding and image size for the lcd_ctrl command sequencer.
// Pure definitions: no latency, no flow control.
package lcd_seq_pkg;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_REFLASH = 3'd0;
  localparam cmd_t CMD_LOAD    = 3'd1;
  localparam cmd_t CMD_SHR     = 3'd2;
  localparam cmd_t CMD_SHL     = 3'd3;
  localparam cmd_t CMD_SHU     = 3'd4;
  localparam cmd_t CMD_SHD     = 3'd5;

  localparam int IMG_N_DEFAULT = 36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOAD,
    ST_GUARD,
    ST_WAIT
  } seq_state_t;

  function automatic logic cmd_legal(input cmd_t c);
    return c <= CMD_SHD;
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Host command handshake: host drives cmd/valid, the sequencer answers with ready.
// A command transfers on the cycle valid and ready are both high.
interface lcd_cmd_sequencer_if;
  import lcd_seq_pkg::*;

  cmd_t host_cmd;
  logic host_valid;
  logic host_ready;

  modport master (output host_cmd, output host_valid, input host_ready);
  modport slave  (input host_cmd, input host_valid, output host_ready);
endinterface

// File: rtl/lcd_seq_fifo.sv
// Synchronous FIFO with registered storage and head-of-queue read; head valid while !empty.
// Pushes while full are refused even if a pop lands in the same cycle; pops while empty are ignored.
module lcd_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Queues host commands and issues them to lcd_ctrl one at a time, streaming the image ROM on LOAD.
// Strobe >=2 cycles after push; host backpressured by FIFO full. Define LCD_SEQ_PERF_EN for the busy-stall counter.
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_N      = IMG_N_DEFAULT,
  parameter int AW         = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_cmd_sequencer_if.slave   host,
  output logic [AW-1:0]        img_addr,
  input  logic [7:0]           img_rdata,
  output cmd_t                 lcd_cmd,
  output logic                 lcd_cmd_valid,
  output logic [7:0]           lcd_datain,
  input  logic                 lcd_busy,
  output logic                 seq_idle,
  output logic                 cmd_err,
  output logic [15:0]          stall_cnt
);

  localparam logic [AW-1:0] LAST_PIX = AW'(IMG_N - 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  cmd_t          fifo_head;
  logic [AW-1:0] pix_cnt;
  logic [7:0]    datain_q;

  lcd_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (3)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (host.host_valid),
    .din   (host.host_cmd),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign host.host_ready = !fifo_full;
  assign seq_idle        = fifo_empty && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    fifo_pop      = 1'b0;
    lcd_cmd_valid = 1'b0;
    lcd_cmd       = CMD_REFLASH;
    cmd_err       = 1'b0;
    case (state)
      ST_IDLE: begin
        // Illegal codes are discarded even while lcd_ctrl is busy.
        if (!fifo_empty) begin
          if (!cmd_legal(fifo_head)) begin
            fifo_pop = 1'b1;
            cmd_err  = 1'b1;
          end else if (!lcd_busy) begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        lcd_cmd_valid = 1'b1;
        lcd_cmd       = fifo_head;
        fifo_pop      = 1'b1;
        state_nxt     = (fifo_head == CMD_LOAD) ? ST_LOAD : ST_GUARD;
      end
      ST_LOAD: begin
        if (pix_cnt == LAST_PIX) state_nxt = ST_GUARD;
      end
      ST_GUARD: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!lcd_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ROM has one cycle of latency, so the address runs one pixel ahead of lcd_datain.
  assign img_addr = (state == ST_LOAD) ? (pix_cnt + AW'(1)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt  <= '0;
      datain_q <= '0;
    end else if (state == ST_LOAD) begin
      pix_cnt  <= pix_cnt + AW'(1);
      datain_q <= img_rdata;
    end else begin
      pix_cnt  <= '0;
    end
  end

  assign lcd_datain = (state == ST_LOAD) ? img_rdata : datain_q;

`ifdef LCD_SEQ_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!fifo_empty && lcd_busy && (state == ST_IDLE || state == ST_WAIT)
                 && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer: LOAD streaming, busy pacing, FIFO full, illegal drop, reset abort, stall counter.
// Outputs are sampled and inputs changed on the falling edge.
module tb_lcd_cmd_sequencer;
  import lcd_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  img_addr;
  logic [7:0]  img_rdata;
  cmd_t        lcd_cmd;
  logic        lcd_cmd_valid;
  logic [7:0]  lcd_datain;
  logic        lcd_busy;
  logic        seq_idle;
  logic        cmd_err;
  logic [15:0] stall_cnt;

  lcd_cmd_sequencer_if hif ();

  lcd_cmd_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .host          (hif),
    .img_addr      (img_addr),
    .img_rdata     (img_rdata),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_datain    (lcd_datain),
    .lcd_busy      (lcd_busy),
    .seq_idle      (seq_idle),
    .cmd_err       (cmd_err),
    .stall_cnt     (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Image ROM with ROM[i] = i and one cycle of read latency.
  always @(posedge clk) img_rdata <= {2'b00, img_addr};

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   err_cnt  = 0;
  cmd_t sq_cmd[$];
  int   sq_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: land on the falling edge and log any strobe or error pulse seen there.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (lcd_cmd_valid) begin
      sq_cmd.push_back(lcd_cmd);
      sq_cyc.push_back(cyc);
    end
    if (cmd_err) err_cnt++;
  endtask

  task automatic push(input cmd_t c);
    hif.host_cmd   = c;
    hif.host_valid = 1'b1;
    step();
    hif.host_valid = 1'b0;
  endtask

  task automatic wait_n(input int n, input int max_cyc);
    int t = 0;
    while (sq_cmd.size() < n && t < max_cyc) begin
      step();
      t++;
    end
    chk("strobe_wait", 32'(sq_cmd.size() >= n), 1);
  endtask

  task automatic do_reset();
    hif.host_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    sq_cmd.delete();
    sq_cyc.delete();
    err_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  cmd_t codes3 [5];
  int   drop_cyc [3];
  int   acc_cyc;
  logic no_strobe;

  initial begin
    reset          = 1'b1;
    lcd_busy       = 1'b0;
    hif.host_cmd   = CMD_REFLASH;
    hif.host_valid = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_host_ready", 32'(hif.host_ready), 1);
    chk("rst_seq_idle",   32'(seq_idle), 1);
    chk("rst_cmd_valid",  32'(lcd_cmd_valid), 0);
    chk("rst_cmd",        32'(lcd_cmd), 0);
    chk("rst_datain",     32'(lcd_datain), 0);
    chk("rst_img_addr",   32'(img_addr), 0);
    chk("rst_cmd_err",    32'(cmd_err), 0);
    chk("rst_stall_cnt",  32'(stall_cnt), 0);
    reset = 1'b0;

    // 1: LOAD streams ROM bytes 0x00..0x23 on consecutive cycles after the strobe
    push(CMD_LOAD);
    wait_n(1, 10);
    chk("load_cmd", 32'(sq_cmd.size() > 0 ? sq_cmd[0] : 3'd7), 32'(CMD_LOAD));
    no_strobe = 1'b1;
    for (int k = 0; k < 36; k++) begin
      step();
      chk($sformatf("load_pix%0d", k), 32'(lcd_datain), 32'(k));
      if (lcd_cmd_valid) no_strobe = 1'b0;
    end
    chk("load_no_restrobe", 32'(no_strobe), 1);
    step();
    chk("load_datain_hold", 32'(lcd_datain), 32'h23);
    chk("load_addr_idle",   32'(img_addr), 0);
    repeat (4) step();
    chk("load_seq_idle",    32'(seq_idle), 1);
    chk("load_strobes",     32'(sq_cmd.size()), 1);

    // 2: three commands paced by lcd_busy high for 3 cycles after each strobe
    do_reset();
    lcd_busy = 1'b1;
    push(CMD_SHR);
    push(CMD_SHR);
    push(CMD_REFLASH);
    lcd_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_n(i + 1, 30);
      lcd_busy = 1'b1;
      repeat (3) step();
      lcd_busy = 1'b0;
      drop_cyc[i] = cyc;
    end
    repeat (6) step();
    chk("pace_count", 32'(sq_cmd.size()), 3);
    if (sq_cmd.size() == 3) begin
      chk("pace_cmd0", 32'(sq_cmd[0]), 32'(CMD_SHR));
      chk("pace_cmd1", 32'(sq_cmd[1]), 32'(CMD_SHR));
      chk("pace_cmd2", 32'(sq_cmd[2]), 32'(CMD_REFLASH));
      for (int i = 1; i < 3; i++) begin
        chk($sformatf("pace_after_busy%0d", i), 32'(sq_cyc[i] > drop_cyc[i-1]), 1);
        chk($sformatf("pace_spacing%0d", i), 32'(sq_cyc[i] - sq_cyc[i-1] >= 2), 1);
      end
    end

    // 3: five back-to-back pushes into a depth-4 FIFO with lcd_busy held
    do_reset();
    codes3[0] = CMD_SHR;
    codes3[1] = CMD_SHL;
    codes3[2] = CMD_SHU;
    codes3[3] = CMD_SHD;
    codes3[4] = CMD_REFLASH;
    lcd_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_ready%0d", i), 32'(hif.host_ready), 1);
      hif.host_cmd   = codes3[i];
      hif.host_valid = 1'b1;
      step();
    end
    chk("full_ready", 32'(hif.host_ready), 0);
    hif.host_cmd = codes3[4];
    repeat (3) step();
    chk("full_ready_hold", 32'(hif.host_ready), 0);
    chk("full_no_strobe",  32'(sq_cmd.size()), 0);
    lcd_busy = 1'b0;
    acc_cyc = -1;
    for (int t = 0; t < 10 && acc_cyc < 0; t++) begin
      step();
      if (hif.host_ready) acc_cyc = cyc;
    end
    chk("accept_seen",      32'(acc_cyc >= 0), 1);
    chk("accept_after_pop", 32'(sq_cmd.size()), 1);
    step();
    hif.host_valid = 1'b0;
    wait_n(5, 80);
    chk("drain_count", 32'(sq_cmd.size()), 5);
    if (sq_cmd.size() == 5) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("drain_cmd%0d", i), 32'(sq_cmd[i]), 32'(codes3[i]));
    end

    // 4: illegal code dropped with a single cmd_err pulse, SHL issued next
    do_reset();
    push(3'd7);
    push(CMD_SHL);
    wait_n(1, 20);
    repeat (8) step();
    chk("illegal_err_pulses", 32'(err_cnt), 1);
    chk("illegal_strobes",    32'(sq_cmd.size()), 1);
    chk("illegal_next_cmd",   32'(sq_cmd.size() > 0 ? sq_cmd[0] : 3'd7), 32'(CMD_SHL));

    // 5: reset at pixel 10 of a LOAD, with another command still queued
    do_reset();
    push(CMD_LOAD);
    push(CMD_SHR);
    wait_n(1, 10);
    repeat (11) step();
    chk("abort_pix10", 32'(lcd_datain), 32'h0a);
    reset = 1'b1;
    step();
    chk("abort_cmd_valid",  32'(lcd_cmd_valid), 0);
    chk("abort_seq_idle",   32'(seq_idle), 1);
    chk("abort_host_ready", 32'(hif.host_ready), 1);
    chk("abort_img_addr",   32'(img_addr), 0);
    chk("abort_datain",     32'(lcd_datain), 0);
    reset = 1'b0;
    sq_cmd.delete();
    sq_cyc.delete();
    repeat (10) step();
    chk("abort_fifo_empty", 32'(sq_cmd.size()), 0);
    chk("abort_still_idle", 32'(seq_idle), 1);

    // 6: 20 busy cycles with one queued command
    do_reset();
    lcd_busy = 1'b1;
    push(CMD_SHR);
    repeat (20) step();
`ifdef LCD_SEQ_PERF_EN
    chk("stall_cnt_20", 32'(stall_cnt), 20);
`else
    chk("stall_cnt_off", 32'(stall_cnt), 0);
`endif
    lcd_busy = 1'b0;
    wait_n(1, 20);
    chk("stall_cmd", 32'(sq_cmd.size() > 0 ? sq_cmd[0] : 3'd7), 32'(CMD_SHR));
    repeat (6) step();
`ifdef LCD_SEQ_PERF_EN
    chk("stall_cnt_hold", 32'(stall_cnt), 20);
`else
    chk("stall_cnt_off_hold", 32'(stall_cnt), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
